// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial ripple subtractor.
//   sub_state_e : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width() : bit-counter width for a given operand width
package serial_ripple_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sub_state_e;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_sub.sv
// Combinational full subtractor cell: two half subtractors plus an OR.
//   x_i, y_i : operand bits (x - y - bin)
//   bin_i    : borrow in
//   d_o      : difference bit, x ^ y ^ bin
//   bout_o   : borrow out, (~x & y) | (~(x ^ y) & bin)
module serial_ripple_subtractor_full_sub (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic d1;
    logic b1;
    logic b2;

    serial_ripple_subtractor_half_sub u_hs_xy (
        .x_i (x_i),
        .y_i (y_i),
        .d_o (d1),
        .b_o (b1)
    );

    serial_ripple_subtractor_half_sub u_hs_bin (
        .x_i (d1),
        .y_i (bin_i),
        .d_o (d_o),
        .b_o (b2)
    );

    assign bout_o = b1 | b2;

endmodule

// File: rtl/serial_ripple_subtractor_half_sub.sv
// Combinational half subtractor cell.
//   x_i, y_i : operand bits (x - y)
//   d_o      : difference bit
//   b_o      : borrow out
module serial_ripple_subtractor_half_sub (
    input  logic x_i,
    input  logic y_i,
    output logic d_o,
    output logic b_o
);

    assign d_o = x_i ^ y_i;
    assign b_o = ~x_i & y_i;

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, one bit per clock, LSB first.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b sampled at the accept edge)
//   out_valid / out_ready: result handshake, result held until taken
//   diff                 : (a - b) mod 2^WIDTH
//   borrow               : unsigned a < b
//   ovf                  : signed two's-complement overflow
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    sub_state_e      state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             bff_q, bff_d;
    logic             sa_msb_q, sa_msb_d;
    logic             sb_msb_q, sb_msb_d;

    logic fs_d;
    logic fs_bout;

    serial_ripple_subtractor_full_sub u_full_sub (
        .x_i    (sa_q[0]),
        .y_i    (sb_q[0]),
        .bin_i  (bff_q),
        .d_o    (fs_d),
        .bout_o (fs_bout)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bff_d    = bff_q;
        sa_msb_d = sa_msb_q;
        sb_msb_d = sb_msb_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sa_d     = a;
                    sb_d     = b;
                    bff_d    = 1'b0;
                    cnt_d    = '0;
                    sa_msb_d = a[WIDTH-1];
                    sb_msb_d = b[WIDTH-1];
                    state_d  = StRun;
                end
            end
            StRun: begin
                // Result fills from the MSB end so that after WIDTH shifts bit 0 is the LSB.
                diff_d = {fs_d, diff_q[WIDTH-1:1]};
                bff_d  = fs_bout;
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bff_q    <= 1'b0;
            sa_msb_q <= 1'b0;
            sb_msb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bff_q    <= bff_d;
            sa_msb_q <= sa_msb_d;
            sb_msb_q <= sb_msb_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign diff      = diff_q;
    // Flags are only meaningful once the last bit has been processed.
    assign borrow    = out_valid & bff_q;
    assign ovf       = out_valid & (sa_msb_q != sb_msb_q) & (diff_q[WIDTH-1] != sa_msb_q);

endmodule
